mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit, directly downstream of the EX/MEM pipeline register.
//  Turns EX/MEM load/store controls into a req/ack transaction on the data-memory bus.
//  Aligns store lanes and sign/zero-extends load data, and stalls the pipeline until the access completes.
//  rdata_o feeds the MEM/WB register.
// PARAMETERS
//  TIMEOUT  15  max WAIT cycles without mem_ack_i before the access is aborted (1..2^CNT_W-1)
//  CNT_W    4   width of the wait-cycle counter
// PORTS
//  clk_i        in   1   clock, rising edge
//  start_i      in   1   reset, asynchronous, active-low
//  MemRead_i    in   1   load request (from EX/MEM)
//  MemWrite_i   in   1   store request (from EX/MEM); MemRead_i has priority if both are high
//  addr_i       in   32  byte address (EX/MEM ALU result)
//  wdata_i      in   32  store data (EX/MEM RD data)
//  funct3_i     in   3   access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  rdata_o      out  32  formatted load data, registered
//  stall_o      out  1   freeze the PC and the IF/ID, ID/EX and EX/MEM registers
//  err_o        out  1   one-cycle pulse: access timed out
//  misalign_o   out  1   one-cycle pulse: misaligned access trapped (only with the macro)
//  mem_req_o    out  1   bus request, registered
//  mem_we_o     out  1   1 = write, registered
//  mem_addr_o   out  32  word address, {addr_i[31:2],2'b00}, registered
//  mem_be_o     out  4   byte enables, registered
//  mem_wdata_o  out  32  lane-replicated store data, registered
//  mem_rdata_i  in   32  bus read data, valid while mem_ack_i is high
//  mem_ack_i    in   1   bus acknowledge
// BEHAVIOUR
//  Reset (start_i low, async): state=IDLE, wait counter=0; all outputs 0.
//   A reset during WAIT drops mem_req_o immediately; the access is abandoned.
//  FSM states: IDLE, WAIT, DONE.
//   IDLE: if (MemRead_i|MemWrite_i), then stall_o=1 combinationally.
//    At the next edge: load mem_* outputs, set mem_req_o=1, go to WAIT.
//    If neither request is high, stay in IDLE with stall_o=0.
//   WAIT: stall_o=1; mem_* outputs are held stable.
//    On an edge with mem_ack_i=1:
//     - mem_req_o<=0.
//     - For a load, rdata_o<=format(mem_rdata_i).
//     - Go to DONE.
//    Otherwise the counter increments. When counter==TIMEOUT:
//     - mem_req_o<=0, rdata_o<=0, err_o<=1 for 1 cycle.
//     - Go to DONE.
//    If ack and the timeout coincide, the ack wins and err_o stays 0.
//   DONE: stall_o=0 so the pipeline advances on this edge; counter<=0; go to IDLE unconditionally.
//  mem_ack_i is ignored outside WAIT.
//  Latency: zero-wait ack gives stall_o high 2 cycles; each extra ack-wait cycle adds 1.
//  Store lanes (a = addr_i[1:0]):
//   SB: be = 4'b0001<<a; wdata = {4{wdata_i[7:0]}}.
//   SH: be = 4'b0011<<{a[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
//   SW: be = 4'b1111; wdata = wdata_i.
//   Loads: be = 4'b1111, mem_we_o=0.
//  Load format: pick the byte at lane a, or the halfword at lane a[1].
//   B/H sign-extend; BU/HU zero-extend; W passes through.
//   Undefined funct3 values are treated as W.
//  rdata_o holds its value until the next completed load; stores do not change it.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - Misaligned accesses are H/HU with a[0]=1, or W with a!=0.
//   - IDLE goes directly to DONE with no bus request.
//   - misalign_o=1 for 1 cycle (the DONE cycle); rdata_o<=0.
//  MEM_MISALIGN_TRAP_EN undefined:
//   - misalign_o is tied to 0.
//   - Low address bits are ignored: H uses lane a[1]; W ignores a.
// TESTING
//  LW addr 0x100, ack on the 1st WAIT cycle, mem_rdata 0xDEADBEEF:
//   -> req 1 cycle, addr 0x100, be 1111; rdata_o=0xDEADBEEF; stall_o high 2 cycles.
//  SB addr 0x203, wdata 0x000000A5, ack after 3 WAIT cycles:
//   -> we=1, be=1000, wdata=0xA5A5A5A5; stall_o high 5 cycles; rdata_o unchanged.
//  LB/LBU addr 0x2, mem_rdata 0x00800000:
//   -> LB rdata_o=0xFFFFFF80; LBU rdata_o=0x00000080.
//  LW with no ack, TIMEOUT=15:
//   -> req held 15 WAIT cycles, then drops; err_o pulses 1 cycle; rdata_o=0; FSM returns to IDLE.
//  start_i pulled low mid-WAIT:
//   -> req, stall, all outputs 0 asynchronously; an ack arriving after reset is ignored.
//  With MEM_MISALIGN_TRAP_EN, LH addr 0x101:
//   -> no req; misalign_o 1 cycle; stall_o high 1 cycle.
//  Without MEM_MISALIGN_TRAP_EN, LH addr 0x101, mem_rdata 0x1234ABCD:
//   -> rdata_o=0xFFFFABCD.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus sequencing, store lane steering and load extension.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d, mis_q, mis_d, ld_q, ld_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        st_be_s;
  logic [31:0]       st_wdata_s;
  logic              stall_s, trap_s;

  // Byte/halfword selected by the captured lane, then sign/zero-extended; unknown sizes pass as word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction
`endif

  // Store lane steering and misalignment detection for the request presented in IDLE.
  always_comb begin
    st_be_s    = 4'b1111;
    st_wdata_s = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_be_s    = 4'b0001 << addr_i[1:0];
        st_wdata_s = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_s    = 4'b0011 << {addr_i[1], 1'b0};
        st_wdata_s = {2{wdata_i[15:0]}};
      end
      default: begin
        st_be_s    = 4'b1111;
        st_wdata_s = wdata_i;
      end
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    trap_s = misaligned(funct3_i, addr_i[1:0]);
`else
    trap_s = 1'b0;
`endif
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead_i || MemWrite_i) begin
          stall_s = 1'b1;
          ld_d    = MemRead_i;
          f3_d    = funct3_i;
          lane_d  = addr_i[1:0];
          if (trap_s) begin
            mis_d   = 1'b1;
            rdata_d = 32'h0000_0000;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = ~MemRead_i;
            addr_d  = {addr_i[31:2], 2'b00};
            be_d    = MemRead_i ? 4'b1111 : st_be_s;
            wdata_d = st_wdata_s;
            state_d = S_WAIT;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      S_WAIT: begin
        stall_s = 1'b1;
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (ld_q) begin
            rdata_d = fmt_load(f3_q, lane_q, mem_rdata_i);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign stall_o     = stall_s;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign misalign_o  = mis_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a simple ack-delaying bus model.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        start_i, MemRead_i, MemWrite_i, mem_ack_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic [2:0]  funct3_i;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, err_o, misalign_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_unit #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i(clk_i), .start_i(start_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .err_o(err_o), .misalign_o(misalign_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          ack_wait;
    logic [31:0] bus;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    int          exp_stall;
    int          exp_req;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3, input int aw,
                              input logic [31:0] bus, input logic [31:0] er, input logic [3:0] eb,
                              input logic [31:0] ew, input int es, input int eq,
                              input logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.ack_wait = aw;
    v.bus = bus; v.exp_rdata = er; v.exp_we = wr & ~rd; v.exp_be = eb; v.exp_wdata = ew;
    v.exp_addr = {addr[31:2], 2'b00}; v.exp_stall = es; v.exp_req = eq; v.exp_err = ee;
    v.exp_mis = 1'b0;
    return v;
  endfunction

  // Called at posedge+1; drives one access to completion, sampling at each negedge.
  task automatic do_access(input int idx, input vec_t v);
    int stall_n = 0, req_n = 0, waits = 0;
    bit done = 0;
    logic [31:0] addr_s = 32'h0, wdata_s = 32'h0, rdata_s = 32'h0;
    logic [3:0]  be_s = 4'h0;
    logic        we_s = 1'b0, err_s = 1'b0, mis_s = 1'b0;
    MemRead_i = v.rd; MemWrite_i = v.wr; addr_i = v.addr; wdata_i = v.wdata;
    funct3_i = v.f3; mem_ack_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (stall_o) stall_n++;
      if (mem_req_o) begin
        req_n++;
        addr_s = mem_addr_o; be_s = mem_be_o; we_s = mem_we_o; wdata_s = mem_wdata_o;
        if (waits == v.ack_wait) begin
          mem_ack_i = 1'b1; mem_rdata_i = v.bus;
        end else begin
          waits++; mem_ack_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
        end
      end else begin
        mem_ack_i = 1'b0;
      end
      if (!stall_o) begin
        done = 1; err_s = err_o; mis_s = misalign_o; rdata_s = rdata_o;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0;
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL v%0d completion: stall never dropped within 40 cycles", idx);
    end
    chk($sformatf("v%0d stall_cycles", idx), stall_n, v.exp_stall);
    chk($sformatf("v%0d req_cycles", idx), req_n, v.exp_req);
    chk($sformatf("v%0d rdata", idx), rdata_s, v.exp_rdata);
    chk($sformatf("v%0d err", idx), {31'b0, err_s}, {31'b0, v.exp_err});
    chk($sformatf("v%0d misalign", idx), {31'b0, mis_s}, {31'b0, v.exp_mis});
    if (v.exp_req != 0) begin
      chk($sformatf("v%0d we", idx), {31'b0, we_s}, {31'b0, v.exp_we});
      chk($sformatf("v%0d be", idx), {28'b0, be_s}, {28'b0, v.exp_be});
      chk($sformatf("v%0d addr", idx), addr_s, v.exp_addr);
      if (v.exp_we) chk($sformatf("v%0d wdata", idx), wdata_s, v.exp_wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd    wr    addr          wdata         f3     aw  bus           exp_rdata     be       exp_wdata     st  rq  err
    vecs[0]  = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b010, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0,        2,  1,  1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 3,  32'h0,        32'hDEAD_BEEF, 4'b1000, 32'hA5A5_A5A5, 5,  4,  1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0000_0002, 32'h0,        3'b000, 0,  32'h0080_0000, 32'hFFFF_FF80, 4'b1111, 32'h0,        2,  1,  1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0000_0002, 32'h0,        3'b100, 0,  32'h0080_0000, 32'h0000_0080, 4'b1111, 32'h0,        2,  1,  1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b001, 1,  32'h8001_1234, 32'hFFFF_8001, 4'b1111, 32'h0,        3,  2,  1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0000_0102, 32'h0,        3'b101, 0,  32'h8001_1234, 32'h0000_8001, 4'b1111, 32'h0,        2,  1,  1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 32'h0000_0302, 32'h0000_BEEF, 3'b001, 0,  32'h0,        32'h0000_8001, 4'b1100, 32'hBEEF_BEEF, 2,  1,  1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 3'b010, 2,  32'h0,        32'h0000_8001, 4'b1111, 32'h1234_5678, 4,  3,  1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 32'h0000_0201, 32'hFFFF_FF3C, 3'b000, 0,  32'h0,        32'h0000_8001, 4'b0010, 32'h3C3C_3C3C, 2,  1,  1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0000_0001, 32'h0,        3'b000, 0,  32'h0000_7F00, 32'h0000_007F, 4'b1111, 32'h0,        2,  1,  1'b0);
    vecs[10] = mk(1'b1, 1'b1, 32'h0000_0008, 32'h0,        3'b011, 0,  32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0,        2,  1,  1'b0);
    vecs[11] = mk(1'b1, 1'b0, 32'h0000_0101, 32'h0,        3'b001, 0,  32'h1234_ABCD, 32'hFFFF_ABCD, 4'b1111, 32'h0,        2,  1,  1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[11].exp_rdata = 32'h0; vecs[11].exp_stall = 1; vecs[11].exp_req = 0; vecs[11].exp_mis = 1'b1;
`endif
    // ack on the very cycle the timeout would fire: ack wins
    vecs[12] = mk(1'b1, 1'b0, 32'h0000_0600, 32'h0,        3'b010, 14, 32'h1357_9BDF, 32'h1357_9BDF, 4'b1111, 32'h0,        16, 15, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0000_0500, 32'h0,        3'b010, 99, 32'h0,        32'h0,        4'b1111, 32'h0,        16, 15, 1'b1);

    start_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    funct3_i = 3'b000; mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    #12;
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst stall", {31'b0, stall_o}, 32'h0);
    chk("rst req", {31'b0, mem_req_o}, 32'h0);
    chk("rst err_mis_we", {29'b0, err_o, misalign_o, mem_we_o}, 32'h0);
    chk("rst be", {28'b0, mem_be_o}, 32'h0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst wdata", mem_wdata_o, 32'h0);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 14; i++) begin
      do_access(i, vecs[i]);
    end
    // err_o must be a single-cycle pulse
    #4;
    chk("timeout err_pulse_end", {31'b0, err_o}, 32'h0);
    chk("timeout idle_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk_i); #1;

    // Ack while idle with no request is ignored
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    chk("idle_ack req", {31'b0, mem_req_o}, 32'h0);
    chk("idle_ack rdata", rdata_o, 32'h0);

    // Load rdata, then reset in the middle of a second access
    do_access(100, mk(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b010, 0, 32'h0BAD_F00D, 32'h0BAD_F00D,
                      4'b1111, 32'h0, 2, 1, 1'b0));
    MemRead_i = 1'b1; addr_i = 32'h0000_0700; funct3_i = 3'b010;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("mid_wait req", {31'b0, mem_req_o}, 32'h1);
    #2;
    start_i = 1'b0; MemRead_i = 1'b0;
    #1;
    chk("async_rst req", {31'b0, mem_req_o}, 32'h0);
    chk("async_rst stall", {31'b0, stall_o}, 32'h0);
    chk("async_rst rdata", rdata_o, 32'h0);
    chk("async_rst addr", mem_addr_o, 32'h0);
    chk("async_rst be", {28'b0, mem_be_o}, 32'h0);
    #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("post_rst_ack req", {31'b0, mem_req_o}, 32'h0);
    chk("post_rst_ack stall", {31'b0, stall_o}, 32'h0);
    chk("post_rst_ack rdata", rdata_o, 32'h0);
    chk("post_rst_ack err", {31'b0, err_o}, 32'h0);
    mem_ack_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
